// File: rtl/axi_mem_slave_pkg.sv
// Shared types, response codes and burst address arithmetic for the AXI4 slave memory.
// Addresses are handled at AXI_AW bits internally; ADDR_W must not exceed it.
package axi_mem_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;

    localparam int unsigned AXI_AW = 32;

    function automatic logic [AXI_AW-1:0] axi_next_addr(input logic [AXI_AW-1:0] addr,
                                                        input logic [2:0]        size,
                                                        input logic [7:0]        len,
                                                        input burst_e            burst);
        logic [AXI_AW-1:0] step;
        logic [AXI_AW-1:0] incr;
        logic [AXI_AW-1:0] wrap_mask;
        logic [AXI_AW-1:0] next;
        step      = AXI_AW'(1) << size;
        // Align down first so an unaligned first beat lands on the next container.
        incr      = (addr & ~(step - AXI_AW'(1))) + step;
        wrap_mask = ((AXI_AW'(len) + AXI_AW'(1)) << size) - AXI_AW'(1);
        unique case (burst)
            FIXED:   next = addr;
            INCR:    next = incr;
            WRAP:    next = (addr & ~wrap_mask) | (incr & wrap_mask);
            default: next = addr;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master and the slave memory model.
interface axi_mem_slave_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_mem_slave_burst_addr.sv
// Per-burst address walker: current beat address, memory word index, lane mask, last and error.
// Loaded on start, stepped on advance; one instance per engine.
module axi_mem_slave_burst_addr
    import axi_mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [7:0]                   start_len,
    input  logic [2:0]                   start_size,
    input  logic [1:0]                   start_burst,
    input  logic                         advance,
    output logic [$clog2(MEM_BYTES)-1:0] mem_idx,
    output logic [DATA_W/8-1:0]          lane_mask,
    output logic                         last,
    output logic                         err
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(STRB_W);
    localparam int unsigned MEM_AW = $clog2(MEM_BYTES);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, cnt_q;
    logic [2:0]        size_q;
    burst_e            burst_q, start_burst_e;
    logic              burst_err_q, start_err, range_err;
    int unsigned       lo, hi, nbytes;

    assign start_burst_e = burst_e'(start_burst);

    // Burst-wide errors are decided once at address acceptance.
    always_comb begin
        start_err = (start_size > 3'(LANE_W)) || (start_burst_e == RSVD) ||
                    ((start_burst_e == WRAP) && !(start_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

    assign addr_d = ADDR_W'(axi_next_addr(AXI_AW'(addr_q), size_q, len_q, burst_q));

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= FIXED;
            burst_err_q <= 1'b0;
        end else if (start) begin
            addr_q      <= start_addr;
            len_q       <= start_len;
            cnt_q       <= '0;
            size_q      <= start_size;
            burst_q     <= start_burst_e;
            burst_err_q <= start_err;
        end else if (advance) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_q + 8'd1;
        end
    end

    assign range_err = {1'b0, addr_q} >= (ADDR_W + 1)'(MEM_BYTES);
    assign err       = burst_err_q | range_err;
    assign last      = (cnt_q == len_q);
    assign mem_idx   = {addr_q[MEM_AW-1:LANE_W], LANE_W'(0)};

    // Lanes from the start byte up to the end of the size-aligned container.
    always_comb begin
        lane_mask = '0;
        lo        = 32'(addr_q[LANE_W-1:0]);
        nbytes    = 32'(1) << size_q;
        hi        = (lo & ~(nbytes - 1)) + nbytes;
        for (int unsigned k = 0; k < STRB_W; k++) begin
            lane_mask[k] = (k >= lo) && (k < hi) && !burst_err_q;
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// Synthesisable AXI4 slave memory: independent write and read engines over a byte array.
// Reads sample the array on the edge that raises rvalid, so same-cycle writes return old data.
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned RD_LAT    = 1
) (
    input logic           aclk,
    input logic           areset,
    axi_mem_slave_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned MEM_AW = $clog2(MEM_BYTES);

    logic [7:0] mem [MEM_BYTES];

    // Write engine
    wstate_e           wstate_q, wstate_d;
    logic [ID_W-1:0]   wid_q;
    logic              werr_q, w_start, w_adv, w_last, w_err;
    logic [MEM_AW-1:0] w_idx;
    logic [STRB_W-1:0] w_mask;

    axi_mem_slave_burst_addr #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_BYTES(MEM_BYTES)
    ) u_waddr (
        .aclk       (aclk),
        .areset     (areset),
        .start      (w_start),
        .start_addr (bus.awaddr),
        .start_len  (bus.awlen),
        .start_size (bus.awsize),
        .start_burst(bus.awburst),
        .advance    (w_adv),
        .mem_idx    (w_idx),
        .lane_mask  (w_mask),
        .last       (w_last),
        .err        (w_err)
    );

    always_comb begin
        wstate_d    = wstate_q;
        w_start     = 1'b0;
        w_adv       = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                bus.awready = 1'b1;
                if (bus.awvalid) begin
                    w_start  = 1'b1;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid) begin
                    w_adv = 1'b1;
                    if (w_last) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign bus.bid   = wid_q;
    assign bus.bresp = werr_q ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            werr_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            if (w_start) begin
                wid_q  <= bus.awid;
                werr_q <= 1'b0;
            end else if (w_adv) begin
                werr_q <= werr_q | w_err | (bus.wlast != w_last);
            end
        end
    end

    // A wlast mismatch still writes the beat; only address/burst errors drop it.
    always_ff @(posedge aclk) begin
        if (w_adv && !w_err) begin
            for (int unsigned k = 0; k < STRB_W; k++) begin
                if (w_mask[k] && bus.wstrb[k]) mem[w_idx | MEM_AW'(k)] <= bus.wdata[8*k +: 8];
            end
        end
    end

    // Read engine
    rstate_e           rstate_q, rstate_d;
    logic [2:0]        lat_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q, r_word;
    logic [1:0]        rresp_q;
    logic              rlast_q, r_start, r_adv, r_load, r_last, r_err;
    logic [MEM_AW-1:0] r_idx;
    logic [STRB_W-1:0] r_mask;

    axi_mem_slave_burst_addr #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_BYTES(MEM_BYTES)
    ) u_raddr (
        .aclk       (aclk),
        .areset     (areset),
        .start      (r_start),
        .start_addr (bus.araddr),
        .start_len  (bus.arlen),
        .start_size (bus.arsize),
        .start_burst(bus.arburst),
        .advance    (r_adv),
        .mem_idx    (r_idx),
        .lane_mask  (r_mask),
        .last       (r_last),
        .err        (r_err)
    );

    always_comb begin
        rstate_d    = rstate_q;
        r_start     = 1'b0;
        r_adv       = 1'b0;
        r_load      = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                bus.arready = 1'b1;
                if (bus.arvalid) begin
                    r_start  = 1'b1;
                    rstate_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_q == 3'(RD_LAT - 1)) begin
                    r_load   = 1'b1;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready) begin
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        r_adv    = 1'b1;
                        rstate_d = R_WAIT;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        r_word = '0;
        for (int unsigned k = 0; k < STRB_W; k++) begin
            if (r_mask[k] && !r_err) r_word[8*k +: 8] = mem[r_idx | MEM_AW'(k)];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate_q <= R_IDLE;
            lat_q    <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            lat_q    <= (rstate_q == R_WAIT && !r_load) ? lat_q + 3'd1 : 3'd0;
            if (r_start) rid_q <= bus.arid;
            if (r_load) begin
                rdata_q <= r_word;
                rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
                rlast_q <= r_last;
            end
        end
    end

    assign bus.rid   = rid_q;
    assign bus.rdata = rdata_q;
    assign bus.rresp = rresp_q;
    assign bus.rlast = (rstate_q == R_DATA) && rlast_q;

endmodule
